demux1to4_buffered: RTL and testbench
=====================================

# demux1to4_buffered

Registered 1-to-4 demultiplexer with valid/ready handshakes, the distributing counterpart of the team's 4:1 select mux. One input stream carries a 2-bit destination select per item. Each item is steered into a one-entry holding register for the selected output channel. Each channel drains independently to its own consumer and keeps a saturating count of delivered items. It sits upstream of the four per-lane consumers that the mux later recombines.

## Interface
- WIDTH, 8, data width of one item
- CNT_W, 8, width of each per-channel delivered counter
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  an item is offered on in_data/in_sel
- in_ready  output  1  block accepts the offered item this cycle
- in_sel  input  2  destination channel; 0 maps to channel 0, 3 maps to channel 3
- in_data  input  WIDTH  item payload
- out_valid  output  4  bit k: channel k holds an item
- out_ready  input  4  bit k: consumer k takes the item this cycle
- out_data  output  4*WIDTH  channel k payload at [k*WIDTH +: WIDTH]
- out_count  output  4*CNT_W  channel k delivered count at [k*CNT_W +: CNT_W]

## Operation
- Per channel k: full bit (drives out_valid[k]), data register, counter.
- Accept: acc = in_valid && in_ready.
- in_ready = !out_valid[in_sel] || out_ready[in_sel]. It is combinational from in_sel, out_valid and out_ready. It is evaluated whether or not in_valid is high.
- Pop on channel k: pop_k = out_valid[k] && out_ready[k].
- Load on channel k: ld_k = acc && (in_sel == k). Only one channel loads per cycle.
- Full-bit update: next out_valid[k] = ld_k || (out_valid[k] && !pop_k).
- Data register: on ld_k, out_data[k] <= in_data. Otherwise it holds, including after pop, so stale data stays visible while out_valid is 0.
- Simultaneous pop_k and ld_k on the same channel: the new item replaces the popped one with no bubble, and out_valid[k] stays 1.
- Counter: on pop_k, counter k increments by 1. It saturates at 2^CNT_W-1 and never wraps.
- Channels not selected are unaffected by input activity. Pops on different channels in the same cycle are all honoured.
- Ordering: items to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Invalid cases: none. in_sel is fully decoded, and in_data/in_sel are don't-care when in_valid is 0.

## Timing
- Reset (rst high at a clk edge): out_valid = 4'b0000, all out_data = 0, all out_count = 0. in_ready is then 1 for any in_sel.
- Reset mid-operation: held items are discarded without being counted. Any accept or pop presented in the reset cycle has no effect.
- Latency: an item accepted at edge N appears with out_valid[k] = 1 in the cycle after edge N.
- Throughput: one item per cycle into any channel whose consumer keeps out_ready high.
- Stability: while out_valid[k] && !out_ready[k], out_data[k] is held constant. Channel k then blocks only inputs with in_sel == k.
- Counter update: visible the cycle after the pop edge.

## Test plan
- Reset, then send in_data 0xA5 with in_sel=2 and all out_ready=1 -> out_valid = 4'b0100 next cycle with channel 2 data 0xA5; count2 = 1 one cycle later; other counts 0.
- Hold out_ready[1]=0 and send 0x11 then 0x22 to channel 1 -> 0x11 is held; in_ready = 0 for in_sel=1 but 1 for in_sel=0; after out_ready[1]=1, 0x11 then 0x22 are delivered in order.
- Channel 3 full with out_ready[3]=1 while a new item 0x7E arrives for channel 3 in the same cycle -> in_ready = 1; out_valid[3] stays 1 with data 0x7E the next cycle; count3 increments by 1.
- Load one item into each channel, then raise out_ready = 4'b1111 for one cycle -> all four pop together, out_valid = 0, each count = 1.
- With CNT_W=8, deliver 300 items on channel 0 -> count0 stops at 255.
- Load items into channels 0 and 2, then assert rst for one cycle -> out_valid = 0, counts = 0, in_ready = 1.

Source files
------------

// File: rtl/demux1to4_buffered.sv
// Registered 1-to-4 demultiplexer: each input item is steered by in_sel into a
// one-entry holding register per channel, drained independently with a saturating delivery count.
module demux1to4_buffered #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [4*CNT_W-1:0]   out_count
);

  logic [3:0]       vld_p0;
  logic [WIDTH-1:0] data_p0 [4];
  logic [CNT_W-1:0] cnt_p0  [4];
  logic             acc;
  logic [3:0]       ld;
  logic [3:0]       pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A full channel still accepts when its consumer drains it in the same cycle.
  assign in_ready = !vld_p0[in_sel] || out_ready[in_sel];
  assign acc      = in_valid && in_ready;
  assign pop      = vld_p0 & out_ready;

  always_comb begin
    ld = 4'b0000;
    if (acc) ld[in_sel] = 1'b1;
  end

  // Stage p0: holding registers and delivery counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        data_p0[k] <= '0;
        cnt_p0[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        vld_p0[k] <= ld[k] || (vld_p0[k] && !pop[k]);
        if (ld[k])  data_p0[k] <= in_data;
        if (pop[k]) cnt_p0[k]  <= sat_inc(cnt_p0[k]);
      end
    end
  end

  assign out_valid = vld_p0;

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign out_data[g*WIDTH +: WIDTH]  = data_p0[g];
    assign out_count[g*CNT_W +: CNT_W] = cnt_p0[g];
  end

endmodule

// File: tb/tb_demux1to4_buffered.sv
// Bench for demux1to4_buffered: occupancy/delivery model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux1to4_buffered;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_sel = 2'd0;
  logic [WIDTH-1:0]   in_data = '0;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready = 4'b0000;
  logic [4*WIDTH-1:0] out_data;
  logic [4*CNT_W-1:0] out_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: items held per channel, last payload loaded, total deliveries.
  int         m_n     [4];
  logic [7:0] m_last  [4];
  int         m_deliv [4];

  demux1to4_buffered #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_count(input int k);
    return (m_deliv[k] > CMAX) ? CMAX : m_deliv[k];
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_n[k] = 0; m_last[k] = 8'h00; m_deliv[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_n[k] = 0; m_last[k] = 8'h00; m_deliv[k] = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && ((m_n[in_sel] == 0) || out_ready[in_sel]);
      for (int k = 0; k < 4; k++) begin
        if (m_n[k] > 0 && out_ready[k]) begin
          m_n[k]--;
          m_deliv[k]++;
        end
      end
      if (acc) begin
        m_n[in_sel]++;
        m_last[in_sel] = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(m_n[k] != 0));
        chk($sformatf("data%0d", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(m_last[k]));
        chk($sformatf("count%0d", k), 32'(out_count[k*CNT_W +: CNT_W]), 32'(exp_count(k)));
      end
      chk("in_ready", 32'(in_ready), 32'((m_n[in_sel] == 0) || out_ready[in_sel]));
    end
  end

  task automatic set(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] dch(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  function automatic logic [7:0] cch(input int k);
    return out_count[k*CNT_W +: CNT_W];
  endfunction

  initial begin
    rst = 1'b1;
    set(1'b0, 2'd0, 8'h00, 4'b0000);
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    for (int s = 0; s < 4; s++) begin
      set(1'b0, 2'(s), 8'h00, 4'b0000);
      #1 chk("rst_in_ready", 32'(in_ready), 32'h1);
    end

    // Single item to channel 2
    set(1'b1, 2'd2, 8'hA5, 4'b1111);
    tick();
    chk("t1_valid", 32'(out_valid), 32'h4);
    chk("t1_data2", 32'(dch(2)), 32'hA5);
    set(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    chk("t1_count2", 32'(cch(2)), 32'h1);
    chk("t1_count0", 32'(cch(0)), 32'h0);

    // Backpressure on channel 1
    set(1'b1, 2'd1, 8'h11, 4'b0000);
    tick();
    set(1'b1, 2'd1, 8'h22, 4'b0000);
    #1 chk("t2_block1", 32'(in_ready), 32'h0);
    tick();
    chk("t2_held", 32'(dch(1)), 32'h11);
    set(1'b0, 2'd0, 8'h00, 4'b0000);
    #1 chk("t2_free0", 32'(in_ready), 32'h1);
    set(1'b1, 2'd1, 8'h22, 4'b0010);
    #1 chk("t2_pass1", 32'(in_ready), 32'h1);
    tick();
    chk("t2_data22", 32'(dch(1)), 32'h22);
    chk("t2_cnt1a", 32'(cch(1)), 32'h1);
    set(1'b0, 2'd0, 8'h00, 4'b0010);
    tick();
    chk("t2_cnt1b", 32'(cch(1)), 32'h2);
    chk("t2_empty", 32'(out_valid), 32'h0);

    // Simultaneous pop and load on channel 3
    set(1'b1, 2'd3, 8'h33, 4'b0000);
    tick();
    set(1'b1, 2'd3, 8'h7E, 4'b1000);
    #1 chk("t3_ready", 32'(in_ready), 32'h1);
    tick();
    chk("t3_valid3", 32'(out_valid[3]), 32'h1);
    chk("t3_data3", 32'(dch(3)), 32'h7E);
    chk("t3_cnt3", 32'(cch(3)), 32'h1);
    set(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    chk("t3_cnt3b", 32'(cch(3)), 32'h2);

    // Fill all four, drain together
    for (int k = 0; k < 4; k++) begin
      set(1'b1, 2'(k), 8'(8'h40 + k), 4'b0000);
      tick();
    end
    chk("t4_full", 32'(out_valid), 32'hF);
    set(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    chk("t4_empty", 32'(out_valid), 32'h0);
    chk("t4_cnt0", 32'(cch(0)), 32'h1);
    chk("t4_cnt1", 32'(cch(1)), 32'h3);
    chk("t4_cnt2", 32'(cch(2)), 32'h2);
    chk("t4_cnt3", 32'(cch(3)), 32'h3);

    // Counter saturation on channel 0
    for (int i = 0; i < 300; i++) begin
      set(1'b1, 2'd0, 8'(i), 4'b0001);
      tick();
    end
    set(1'b0, 2'd0, 8'h00, 4'b0001);
    tick();
    chk("t5_sat", 32'(cch(0)), 32'd255);

    // Reset mid-operation
    set(1'b1, 2'd0, 8'h55, 4'b0000);
    tick();
    set(1'b1, 2'd2, 8'h66, 4'b0000);
    tick();
    chk("t6_pre", 32'(out_valid), 32'h5);
    rst = 1'b1;
    set(1'b1, 2'd1, 8'h77, 4'b1111);
    tick();
    rst = 1'b0;
    set(1'b0, 2'd0, 8'h00, 4'b0000);
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_count", 32'(out_count), 32'h0);
    #1 chk("t6_ready", 32'(in_ready), 32'h1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      set(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
          4'($urandom & $urandom));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    set(1'b0, 2'd0, 8'h00, 4'b1111);
    tick();
    chk("final_drain", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
